// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch FSM states, PC step, NOP encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/ready channel between the fetch unit and imem.
interface fetch_pc_unit_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_pc_unit_pc_reg.sv
// Program counter register with load enable and synchronous reset to RESET_PC.
module pc_reg #(
    parameter int unsigned      ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= RESET_PC;
        else if (en) q <= d;
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC ownership, imem handshake, stall/redirect/flush handling, IF/ID register.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned INSTR_W  = 32,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    fetch_pc_unit_if.master     imem,
    input  logic [ADDR_W-1:0]   next_pc,
    input  logic                pc_src,
    input  logic                stall,
    input  logic                flush,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   incr_pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic                if_id_valid
);
    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic [INSTR_W-1:0]  hold_buf_q, hold_buf_d;
    logic [INSTR_W-1:0]  id_instr_d;
    logic [ADDR_W-1:0]   id_pc_d;
    logic                id_valid_d;
    logic                pc_en;
    logic [ADDR_W-1:0]   pc_d;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(ADDR_W'(RESET_PC))) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc)
    );

    assign incr_pc        = pc + ADDR_W'(PC_STEP);
    assign imem.imem_addr = pc;
    assign imem.imem_req  = ~reset & ((state_q == FETCH) | (state_q == DRAIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pend_pc_q   <= '0;
            hold_buf_q  <= '0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            hold_buf_q  <= hold_buf_d;
            if_id_instr <= id_instr_d;
            if_id_pc    <= id_pc_d;
            if_id_valid <= id_valid_d;
        end
    end

    // Next state; priority is redirect > flush > stall > advance
    always_comb begin
        state_d    = state_q;
        pend_pc_d  = pend_pc_q;
        hold_buf_d = hold_buf_q;
        id_instr_d = if_id_instr;
        id_pc_d    = if_id_pc;
        id_valid_d = if_id_valid;
        pc_en      = 1'b0;
        pc_d       = next_pc;

        unique case (state_q)
            FETCH: begin
                if (!imem.imem_ready) begin
                    if (pc_src) begin
                        pend_pc_d = next_pc;
                        state_d   = DRAIN;
                    end else if (flush) begin
                        id_valid_d = 1'b0;
                    end
                end else if (pc_src) begin
                    pc_en      = 1'b1;
                    id_valid_d = 1'b0;
                end else if (flush && stall) begin
                    // Flush beats stall: drop the bubble, refetch the same pc
                    id_valid_d = 1'b0;
                end else if (stall) begin
                    hold_buf_d = imem.imem_rdata;
                    state_d    = HOLD;
                end else begin
                    id_instr_d = imem.imem_rdata;
                    id_pc_d    = pc;
                    id_valid_d = ~flush;
                    pc_en      = 1'b1;
                end
            end
            HOLD: begin
                if (pc_src) begin
                    pc_en      = 1'b1;
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (flush) begin
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    id_instr_d = hold_buf_q;
                    id_pc_d    = pc;
                    id_valid_d = 1'b1;
                    pc_en      = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (pc_src) pend_pc_d = next_pc;
                if (flush)  id_valid_d = 1'b0;
                if (imem.imem_ready) begin
                    // Latest redirect wins, including one arriving on the completing cycle
                    pc_d       = pc_src ? next_pc : pend_pc_q;
                    pc_en      = 1'b1;
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, wait states, stall/HOLD, redirect/DRAIN, wrap, reset.
module tb_fetch_pc_unit;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               pc_src;
    logic               stall;
    logic               flush;
    logic               ready;
    logic               ovr;
    logic [INSTR_W-1:0] ovr_data;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  incr_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc;
    logic               if_id_valid;

    int total = 0;
    int bad   = 0;

    fetch_pc_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem ();

    // Memory model: data tagged with the low address bits unless overridden
    assign imem.imem_ready = ready;
    assign imem.imem_rdata = ovr ? ovr_data : {16'hC0DE, imem.imem_addr[15:0]};
    assign next_pc         = pc_src ? target : incr_pc;

    fetch_pc_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem.master),
        .next_pc     (next_pc),
        .pc_src      (pc_src),
        .stall       (stall),
        .flush       (flush),
        .pc          (pc),
        .incr_pc     (incr_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; pc_src = 1'b0; stall = 1'b0; flush = 1'b0;
        ready = 1'b1; ovr = 1'b0; ovr_data = '0; target = '0;
        tick(); tick();

        // Reset state
        @(negedge clk);
        check("rst_pc",    pc, 64'h0);
        check("rst_req",   64'(imem.imem_req), 64'h0);
        check("rst_valid", 64'(if_id_valid), 64'h0);
        check("rst_instr", 64'(if_id_instr), 64'h0);
        check("rst_idpc",  if_id_pc, 64'h0);
        tick();
        reset = 1'b0;

        // Sequential zero-wait fetch
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_addr", imem.imem_addr, 64'(4 * i));
            check("seq_req",  64'(imem.imem_req), 64'h1);
            if (i > 0) begin
                check("seq_idpc",  if_id_pc, 64'(4 * (i - 1)));
                check("seq_instr", 64'(if_id_instr), 64'(32'hC0DE_0000 | 32'(4 * (i - 1))));
                check("seq_valid", 64'(if_id_valid), 64'h1);
            end else begin
                check("seq_valid0", 64'(if_id_valid), 64'h0);
            end
            tick();
        end

        // Three wait states at 0x10
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_addr", imem.imem_addr, 64'h10);
            check("wait_req",  64'(imem.imem_req), 64'h1);
            check("wait_idpc", if_id_pc, 64'hC);
            tick();
        end
        ready = 1'b1;
        @(negedge clk);
        check("wait_addr4", imem.imem_addr, 64'h10);
        tick();
        @(negedge clk);
        check("wait_idpc_ld", if_id_pc, 64'h10);
        check("wait_addr_nx", imem.imem_addr, 64'h14);
        tick(); tick(); tick();

        // Stall on capture at 0x20, held two cycles in HOLD
        ovr = 1'b1; ovr_data = 32'hDEADBEEF; stall = 1'b1;
        @(negedge clk);
        check("stall_addr", imem.imem_addr, 64'h20);
        tick();
        ovr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_req",  64'(imem.imem_req), 64'h0);
            check("hold_idpc", if_id_pc, 64'h1C);
            check("hold_addr", imem.imem_addr, 64'h20);
            tick();
        end
        stall = 1'b0;
        tick();
        @(negedge clk);
        check("rel_instr", 64'(if_id_instr), 64'hDEADBEEF);
        check("rel_idpc",  if_id_pc, 64'h20);
        check("rel_addr",  imem.imem_addr, 64'h24);
        check("rel_req",   64'(imem.imem_req), 64'h1);
        tick(); tick(); tick();

        // Redirect to 0x100 while waiting at 0x30
        ready = 1'b0; pc_src = 1'b1; target = 64'h100;
        tick();
        pc_src = 1'b0;
        @(negedge clk);
        check("drain_addr", imem.imem_addr, 64'h30);
        check("drain_req",  64'(imem.imem_req), 64'h1);
        tick();
        ready = 1'b1;
        @(negedge clk);
        check("drain_addr2", imem.imem_addr, 64'h30);
        tick();
        @(negedge clk);
        check("redir_addr",  imem.imem_addr, 64'h100);
        check("redir_valid", 64'(if_id_valid), 64'h0);
        check("redir_idpc",  if_id_pc, 64'h2C);

        // Wrap at top of address space
        pc_src = 1'b1; target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        pc_src = 1'b0;
        @(negedge clk);
        check("wrap_pc",   pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_incr", incr_pc, 64'h0);
        tick();
        @(negedge clk);
        check("wrap_addr",  imem.imem_addr, 64'h0);
        check("wrap_idpc",  if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_valid", 64'(if_id_valid), 64'h1);

        // Flush while waiting: IF/ID invalidated, pc held
        ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(if_id_valid), 64'h0);
        check("flush_addr",  imem.imem_addr, 64'h0);

        // Reset during DRAIN
        pc_src = 1'b1; target = 64'h200;
        tick();
        pc_src = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rdrain_req", 64'(imem.imem_req), 64'h0);
        tick();
        @(negedge clk);
        check("rdrain_pc",    pc, 64'h0);
        check("rdrain_valid", 64'(if_id_valid), 64'h0);
        reset = 1'b0;
        #1;
        check("rdrain_req2", 64'(imem.imem_req), 64'h1);
        tick();
        @(negedge clk);
        check("rdrain_pc2", pc, 64'h0);

        // Reset during HOLD
        ready = 1'b1; stall = 1'b1;
        tick();
        @(negedge clk);
        check("rhold_req0", 64'(imem.imem_req), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0; ready = 1'b0;
        @(negedge clk);
        check("rhold_req",   64'(imem.imem_req), 64'h1);
        check("rhold_pc",    pc, 64'h0);
        check("rhold_valid", 64'(if_id_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
